// File: rtl/lsu_align_rmw_pkg.sv
// Shared definitions for the load/store alignment unit.
// Holds the RISC-V funct3 access codes, the FSM state encoding, reset
// polarity, a zero word constant, and the helpers that classify a request
// as illegal or misaligned when it is captured.
package lsu_align_rmw_pkg;

    // Load funct3 codes
    localparam logic [2:0] INST_LB  = 3'b000;
    localparam logic [2:0] INST_LH  = 3'b001;
    localparam logic [2:0] INST_LW  = 3'b010;
    localparam logic [2:0] INST_LD  = 3'b011;
    localparam logic [2:0] INST_LBU = 3'b100;
    localparam logic [2:0] INST_LHU = 3'b101;
    localparam logic [2:0] INST_LWU = 3'b110;

    // Store funct3 codes
    localparam logic [2:0] INST_SB  = 3'b000;
    localparam logic [2:0] INST_SH  = 3'b001;
    localparam logic [2:0] INST_SW  = 3'b010;
    localparam logic [2:0] INST_SD  = 3'b011;

    localparam logic        RST_ENABLE_HIGH = 1'b1;
    localparam logic [63:0] ZERO_WORD       = 64'h0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_RWAIT = 3'd2,
        ST_WREQ  = 3'd3,
        ST_RESP  = 3'd4
    } lsu_state_e;

    // Doubleword and LWU only exist on a 64-bit datapath; the unsigned
    // codes make no sense for stores.
    function automatic logic funct3_illegal(input logic [2:0] f3,
                                            input logic       we,
                                            input logic       is64);
        logic bad;
        bad = 1'b1;
        if (we) begin
            case (f3)
                INST_SB, INST_SH, INST_SW: bad = 1'b0;
                INST_SD:                   bad = ~is64;
                default:                   bad = 1'b1;
            endcase
        end else begin
            case (f3)
                INST_LB, INST_LH, INST_LW, INST_LBU, INST_LHU: bad = 1'b0;
                INST_LD, INST_LWU:                             bad = ~is64;
                default:                                       bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

    // Natural alignment check on the low address bits, keyed by size.
    function automatic logic misaligned(input logic [2:0] f3,
                                        input logic [2:0] low);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = low[0];
            2'b10:   mis = |low[1:0];
            2'b11:   mis = |low[2:0];
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align_rmw_lane_mux.sv
// lsu_lane_mux: combinational byte-lane logic for the LSU.
// Ports:
//   funct3     access size (bits 1:0) and unsigned flag (bit 2)
//   offset     byte offset of the access inside the memory word
//   rdata      word returned by memory
//   wdata      right-aligned store data
//   load_data  addressed sub-word, sign or zero extended
//   store_data store data moved into its byte lanes
//   store_be   byte strobes for the store lanes
//   merged     rdata with the store lanes replaced by store data
module lsu_lane_mux #(
    parameter int XLEN = 32
) (
    input  logic [2:0]                 funct3,
    input  logic [$clog2(XLEN/8)-1:0]  offset,
    input  logic [XLEN-1:0]            rdata,
    input  logic [XLEN-1:0]            wdata,
    output logic [XLEN-1:0]            load_data,
    output logic [XLEN-1:0]            store_data,
    output logic [XLEN/8-1:0]          store_be,
    output logic [XLEN-1:0]            merged
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    logic [OFF_W+2:0] shamt;
    logic [XLEN-1:0]  shifted;
    logic [XLEN-1:0]  size_mask;
    logic [NB-1:0]    be_base;
    logic             sign_bit;

    assign shamt   = {offset, 3'b000};
    assign shifted = rdata >> shamt;

    // size_mask covers the access width at bit 0; a full-width access
    // leaves nothing to extend, so its sign bit is forced low.
    always_comb begin
        size_mask = '0;
        be_base   = '0;
        sign_bit  = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                size_mask[7:0] = '1;
                be_base[0]     = 1'b1;
                sign_bit       = shifted[7];
            end
            2'b01: begin
                size_mask[15:0] = '1;
                be_base[1:0]    = '1;
                sign_bit        = shifted[15];
            end
            2'b10: begin
                size_mask[31:0] = '1;
                be_base[3:0]    = '1;
                sign_bit        = shifted[31];
            end
            default: begin
                size_mask = '1;
                be_base   = '1;
                sign_bit  = 1'b0;
            end
        endcase
        if (funct3[2]) begin
            sign_bit = 1'b0;
        end
    end

    assign load_data  = (shifted & size_mask) | ({XLEN{sign_bit}} & ~size_mask);
    assign store_data = (wdata & size_mask) << shamt;
    assign store_be   = be_base << offset;
    assign merged     = store_data | (rdata & ~(size_mask << shamt));

endmodule

// File: rtl/lsu_align_rmw.sv
// lsu_align_rmw: sequential load/store alignment unit for the memory stage.
// Takes one request at a time, talks to a single-outstanding req/gnt/rvalid
// data RAM port, and returns a one-cycle registered response.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   req_*                    request handshake, opcode, address, data, rd
//   mem_*                    data RAM request/grant/read-return port
//   rsp_*                    writeback response (valid pulse, rd, data, err)
// With USE_BE=0 sub-word stores become read-modify-write with a full-word
// write and all strobes set.
module lsu_align_rmw
    import lsu_align_rmw_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter bit USE_BE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    input  logic [4:0]        req_rd_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    output logic [XLEN/8-1:0] mem_be_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i,
    output logic              rsp_valid_o,
    output logic              rsp_reg_we_o,
    output logic [4:0]        rsp_rd_o,
    output logic [XLEN-1:0]   rsp_data_o,
    output logic              rsp_err_o
);

    localparam int         NB      = XLEN / 8;
    localparam int         OFF_W   = $clog2(NB);
    localparam logic       IS64    = (XLEN == 64);
    localparam logic [1:0] FULL_SZ = (XLEN == 64) ? 2'b11 : 2'b10;

    lsu_state_e        state, state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        funct3_q;
    logic              we_q;
    logic [XLEN-1:0]   wdata_q;
    logic [4:0]        rd_q;
    logic              err_q;
    logic              rsp_we_q;
    logic [XLEN-1:0]   rsp_data_q;
    logic [XLEN-1:0]   merged_q;

    logic              accept;
    logic              req_err;
    logic              req_full;
    logic              full_word;
    logic [XLEN-1:0]   load_data;
    logic [XLEN-1:0]   store_data;
    logic [NB-1:0]     store_be;
    logic [XLEN-1:0]   merged;

    assign accept    = req_valid_i && (state == ST_IDLE);
    assign req_err   = funct3_illegal(req_funct3_i, req_we_i, IS64)
                     | misaligned(req_funct3_i, req_addr_i[2:0]);
    assign req_full  = (req_funct3_i[1:0] == FULL_SZ);
    assign full_word = (funct3_q[1:0] == FULL_SZ);

    lsu_lane_mux #(.XLEN(XLEN)) u_lane_mux (
        .funct3     (funct3_q),
        .offset     (addr_q[OFF_W-1:0]),
        .rdata      (mem_rdata_i),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_data (store_data),
        .store_be   (store_be),
        .merged     (merged)
    );

    // State and request registers. A captured request clears the previous
    // response; the read return either fills the load result or the merged
    // word for the read-modify-write store.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE_HIGH) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            funct3_q   <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rd_q       <= '0;
            err_q      <= 1'b0;
            rsp_we_q   <= 1'b0;
            rsp_data_q <= '0;
            merged_q   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                addr_q     <= req_addr_i;
                funct3_q   <= req_funct3_i;
                we_q       <= req_we_i;
                wdata_q    <= req_wdata_i;
                rd_q       <= req_rd_i;
                err_q      <= req_err;
                rsp_we_q   <= 1'b0;
                rsp_data_q <= ZERO_WORD[XLEN-1:0];
            end
            if (state == ST_RWAIT && mem_rvalid_i) begin
                if (we_q) begin
                    merged_q <= merged;
                end else begin
                    rsp_data_q <= load_data;
                    rsp_we_q   <= 1'b1;
                end
            end
        end
    end

    // Next state. Errors skip memory entirely; stores go straight to the
    // write when strobes are available or the store covers the whole word.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req_valid_i) begin
                    if (req_err) begin
                        state_next = ST_RESP;
                    end else if (req_we_i && (USE_BE || req_full)) begin
                        state_next = ST_WREQ;
                    end else begin
                        state_next = ST_REQ;
                    end
                end
            end
            ST_REQ:   if (mem_gnt_i)    state_next = ST_RWAIT;
            ST_RWAIT: if (mem_rvalid_i) state_next = we_q ? ST_WREQ : ST_RESP;
            ST_WREQ:  if (mem_gnt_i)    state_next = ST_RESP;
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign req_ready_o  = (state == ST_IDLE);
    assign mem_req_o    = (state == ST_REQ) || (state == ST_WREQ);
    assign mem_we_o     = (state == ST_WREQ);
    assign mem_addr_o   = mem_req_o ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign mem_wdata_o  = !mem_we_o ? ZERO_WORD[XLEN-1:0]
                        : ((USE_BE || full_word) ? store_data : merged_q);
    assign mem_be_o     = !mem_we_o ? '0 : (USE_BE ? store_be : {NB{1'b1}});
    assign rsp_valid_o  = (state == ST_RESP);
    assign rsp_reg_we_o = rsp_valid_o && rsp_we_q;
    assign rsp_rd_o     = rsp_valid_o ? rd_q : 5'd0;
    assign rsp_data_o   = rsp_valid_o ? rsp_data_q : ZERO_WORD[XLEN-1:0];
    assign rsp_err_o    = rsp_valid_o && err_q;

endmodule

// File: tb/tb_lsu_align_rmw.sv
// Bench for lsu_align_rmw. Instance "a" is XLEN=32 with byte strobes,
// instance "b" is XLEN=64 with read-modify-write stores. Each instance has
// a small memory responder with programmable grant and read-return delays.
module tb_lsu_align_rmw;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance a: XLEN=32, USE_BE=1
    logic        a_req_valid = 1'b0, a_req_we = 1'b0, a_req_ready;
    logic [2:0]  a_req_funct3 = '0;
    logic [31:0] a_req_addr = '0, a_req_wdata = '0;
    logic [4:0]  a_req_rd = '0;
    logic        a_mem_req, a_mem_we;
    logic [31:0] a_mem_addr, a_mem_wdata;
    logic [3:0]  a_mem_be;
    logic        a_mem_gnt = 1'b0, a_mem_rvalid = 1'b0;
    logic [31:0] a_mem_rdata = '0;
    logic        a_rsp_valid, a_rsp_reg_we, a_rsp_err;
    logic [4:0]  a_rsp_rd;
    logic [31:0] a_rsp_data;

    // Instance b: XLEN=64, USE_BE=0
    logic        b_req_valid = 1'b0, b_req_we = 1'b0, b_req_ready;
    logic [2:0]  b_req_funct3 = '0;
    logic [31:0] b_req_addr = '0;
    logic [63:0] b_req_wdata = '0;
    logic [4:0]  b_req_rd = '0;
    logic        b_mem_req, b_mem_we;
    logic [31:0] b_mem_addr;
    logic [63:0] b_mem_wdata;
    logic [7:0]  b_mem_be;
    logic        b_mem_gnt = 1'b0, b_mem_rvalid = 1'b0;
    logic [63:0] b_mem_rdata = '0;
    logic        b_rsp_valid, b_rsp_reg_we, b_rsp_err;
    logic [4:0]  b_rsp_rd;
    logic [63:0] b_rsp_data;

    lsu_align_rmw #(.XLEN(32), .ADDR_W(32), .USE_BE(1'b1)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_we_i(a_req_we),
        .req_funct3_i(a_req_funct3), .req_addr_i(a_req_addr), .req_wdata_i(a_req_wdata),
        .req_rd_i(a_req_rd),
        .mem_req_o(a_mem_req), .mem_we_o(a_mem_we), .mem_addr_o(a_mem_addr),
        .mem_wdata_o(a_mem_wdata), .mem_be_o(a_mem_be), .mem_gnt_i(a_mem_gnt),
        .mem_rvalid_i(a_mem_rvalid), .mem_rdata_i(a_mem_rdata),
        .rsp_valid_o(a_rsp_valid), .rsp_reg_we_o(a_rsp_reg_we), .rsp_rd_o(a_rsp_rd),
        .rsp_data_o(a_rsp_data), .rsp_err_o(a_rsp_err)
    );

    lsu_align_rmw #(.XLEN(64), .ADDR_W(32), .USE_BE(1'b0)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_we_i(b_req_we),
        .req_funct3_i(b_req_funct3), .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata),
        .req_rd_i(b_req_rd),
        .mem_req_o(b_mem_req), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr),
        .mem_wdata_o(b_mem_wdata), .mem_be_o(b_mem_be), .mem_gnt_i(b_mem_gnt),
        .mem_rvalid_i(b_mem_rvalid), .mem_rdata_i(b_mem_rdata),
        .rsp_valid_o(b_rsp_valid), .rsp_reg_we_o(b_rsp_reg_we), .rsp_rd_o(b_rsp_rd),
        .rsp_data_o(b_rsp_data), .rsp_err_o(b_rsp_err)
    );

    // Memory model state for instance a
    int          a_gnt_delay = 0, a_rv_delay = 0, a_wait = 0, a_rcnt = 0;
    bit          a_rpend = 1'b0;
    logic [31:0] a_mem_word = '0;
    int          a_rd_cnt = 0, a_wr_cnt = 0, a_req_cycles = 0, a_unstable = 0, a_rsp_cnt = 0;
    logic [31:0] a_wr_addr = '0, a_wr_data = '0, a_rd_addr = '0;
    logic [3:0]  a_wr_be = '0;
    logic [68:0] a_snap = '0;
    logic [31:0] a_l_data = '0;
    logic        a_l_err = 1'b0, a_l_we = 1'b0;
    logic [4:0]  a_l_rd = '0;

    // Memory model state for instance b
    int          b_gnt_delay = 0, b_rv_delay = 0, b_wait = 0, b_rcnt = 0;
    bit          b_rpend = 1'b0;
    logic [63:0] b_mem_word = '0;
    int          b_rd_cnt = 0, b_wr_cnt = 0, b_req_cycles = 0, b_unstable = 0, b_rsp_cnt = 0;
    logic [31:0] b_wr_addr = '0, b_rd_addr = '0;
    logic [63:0] b_wr_data = '0;
    logic [7:0]  b_wr_be = '0;
    logic [104:0] b_snap = '0;
    logic [63:0] b_l_data = '0;
    logic        b_l_err = 1'b0, b_l_we = 1'b0;
    logic [4:0]  b_l_rd = '0;

    // Responder a: grants after a_gnt_delay waiting cycles, returns read
    // data a_rv_delay cycles after the earliest legal rvalid, checks that
    // the request stays stable while it is held off, and logs responses.
    always @(negedge clk) begin
        a_mem_rvalid = 1'b0;
        if (a_rpend) begin
            if (a_rcnt == 0) begin
                a_mem_rvalid = 1'b1;
                a_mem_rdata  = a_mem_word;
                a_rpend      = 1'b0;
            end else begin
                a_rcnt--;
            end
        end
        a_mem_gnt = 1'b0;
        if (a_mem_req) begin
            a_req_cycles++;
            if (a_wait == 0) a_snap = {a_mem_addr, a_mem_we, a_mem_wdata, a_mem_be};
            else if (a_snap !== {a_mem_addr, a_mem_we, a_mem_wdata, a_mem_be}) a_unstable++;
            if (a_wait >= a_gnt_delay) begin
                a_mem_gnt = 1'b1;
                a_wait    = 0;
                if (a_mem_we) begin
                    a_wr_cnt++;
                    a_wr_addr = a_mem_addr; a_wr_data = a_mem_wdata; a_wr_be = a_mem_be;
                end else begin
                    a_rd_cnt++;
                    a_rd_addr = a_mem_addr;
                    a_rpend   = 1'b1;
                    a_rcnt    = a_rv_delay;
                end
            end else begin
                a_wait++;
            end
        end else begin
            a_wait = 0;
        end
        if (a_rsp_valid) begin
            a_rsp_cnt++;
            a_l_data = a_rsp_data; a_l_err = a_rsp_err; a_l_we = a_rsp_reg_we; a_l_rd = a_rsp_rd;
        end
    end

    // Responder b: same behaviour for the 64-bit instance.
    always @(negedge clk) begin
        b_mem_rvalid = 1'b0;
        if (b_rpend) begin
            if (b_rcnt == 0) begin
                b_mem_rvalid = 1'b1;
                b_mem_rdata  = b_mem_word;
                b_rpend      = 1'b0;
            end else begin
                b_rcnt--;
            end
        end
        b_mem_gnt = 1'b0;
        if (b_mem_req) begin
            b_req_cycles++;
            if (b_wait == 0) b_snap = {b_mem_addr, b_mem_we, b_mem_wdata, b_mem_be};
            else if (b_snap !== {b_mem_addr, b_mem_we, b_mem_wdata, b_mem_be}) b_unstable++;
            if (b_wait >= b_gnt_delay) begin
                b_mem_gnt = 1'b1;
                b_wait    = 0;
                if (b_mem_we) begin
                    b_wr_cnt++;
                    b_wr_addr = b_mem_addr; b_wr_data = b_mem_wdata; b_wr_be = b_mem_be;
                end else begin
                    b_rd_cnt++;
                    b_rd_addr = b_mem_addr;
                    b_rpend   = 1'b1;
                    b_rcnt    = b_rv_delay;
                end
            end else begin
                b_wait++;
            end
        end else begin
            b_wait = 0;
        end
        if (b_rsp_valid) begin
            b_rsp_cnt++;
            b_l_data = b_rsp_data; b_l_err = b_rsp_err; b_l_we = b_rsp_reg_we; b_l_rd = b_rsp_rd;
        end
    end

    task automatic send_a(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd);
        @(negedge clk);
        a_req_valid = 1'b1; a_req_we = we; a_req_funct3 = f3;
        a_req_addr = addr; a_req_wdata = wdata; a_req_rd = rd;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
    endtask

    task automatic send_b(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [63:0] wdata, input logic [4:0] rd);
        @(negedge clk);
        b_req_valid = 1'b1; b_req_we = we; b_req_funct3 = f3;
        b_req_addr = addr; b_req_wdata = wdata; b_req_rd = rd;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
    endtask

    task automatic idle_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (a_req_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_a_ready got=%b want=1", a_req_ready); end
        total++; if (a_mem_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_a_mem_req got=%b want=0", a_mem_req); end
        total++; if (a_rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_a_rsp_valid got=%b want=0", a_rsp_valid); end
        total++; if (b_req_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_b_ready got=%b want=1", b_req_ready); end
        total++; if (b_mem_be !== 8'h00) begin bad++; $display("[TB] FAIL reset_b_be got=%h want=00", b_mem_be); end
        total++; if (b_rsp_data !== 64'h0) begin bad++; $display("[TB] FAIL reset_b_rsp_data got=%h want=0", b_rsp_data); end
        @(negedge clk);
        rst = 1'b0;
        idle_wait(2);
    endtask

    // Earliest grant and read return: request in REQ right after accept,
    // RWAIT next, response two cycles after the accept edge for one cycle.
    task automatic test_latency();
        a_gnt_delay = 0; a_rv_delay = 0; a_mem_word = 32'h1234_5678;
        send_a(1'b0, 3'b010, 32'h100, 32'h0, 5'd3);
        total++; if (a_mem_req !== 1'b1) begin bad++; $display("[TB] FAIL lat_req got=%b want=1", a_mem_req); end
        @(posedge clk); #1;
        total++; if (a_mem_req !== 1'b0) begin bad++; $display("[TB] FAIL lat_rwait_req got=%b want=0", a_mem_req); end
        @(posedge clk); #1;
        total++; if (a_rsp_valid !== 1'b1) begin bad++; $display("[TB] FAIL lat_rsp_valid got=%b want=1", a_rsp_valid); end
        total++; if (a_rsp_data !== 32'h1234_5678) begin bad++; $display("[TB] FAIL lat_rsp_data got=%h want=12345678", a_rsp_data); end
        total++; if (a_rsp_rd !== 5'd3 || a_rsp_reg_we !== 1'b1) begin bad++; $display("[TB] FAIL lat_rd_we got=%0d/%b want=3/1", a_rsp_rd, a_rsp_reg_we); end
        @(posedge clk); #1;
        total++; if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1) begin bad++; $display("[TB] FAIL lat_pulse valid/ready got=%b/%b want=0/1", a_rsp_valid, a_req_ready); end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3s   [4] = '{3'b000, 3'b101, 3'b001, 3'b100};
        logic [31:0] addrs [4] = '{32'h103, 32'h102, 32'h102, 32'h101};
        logic [31:0] words [4] = '{32'h80FF_1234, 32'h8001_0000, 32'h8001_0000, 32'h80FF_1234};
        logic [4:0]  rds   [4] = '{5'd5, 5'd6, 5'd7, 5'd8};
        logic [31:0] exps  [4] = '{32'hFFFF_FF80, 32'h0000_8001, 32'hFFFF_8001, 32'h0000_0012};
        int n0;
        a_gnt_delay = 0; a_rv_delay = 0;
        for (int i = 0; i < 4; i++) begin
            n0 = a_rsp_cnt; a_mem_word = words[i];
            send_a(1'b0, f3s[i], addrs[i], 32'h0, rds[i]);
            idle_wait(10);
            total++; if (a_rsp_cnt - n0 != 1) begin bad++; $display("[TB] FAIL load%0d_rsp_count got=%0d want=1", i, a_rsp_cnt - n0); end
            total++; if (a_l_data !== exps[i]) begin bad++; $display("[TB] FAIL load%0d_data got=%h want=%h", i, a_l_data, exps[i]); end
            total++; if (a_l_we !== 1'b1 || a_l_err !== 1'b0) begin bad++; $display("[TB] FAIL load%0d_we_err got=%b/%b want=1/0", i, a_l_we, a_l_err); end
            total++; if (a_l_rd !== rds[i]) begin bad++; $display("[TB] FAIL load%0d_rd got=%0d want=%0d", i, a_l_rd, rds[i]); end
            total++; if (a_rd_addr !== 32'h100) begin bad++; $display("[TB] FAIL load%0d_addr got=%h want=00000100", i, a_rd_addr); end
        end
    endtask

    task automatic test_store_be();
        logic [2:0]  f3s   [2] = '{3'b000, 3'b001};
        logic [31:0] addrs [2] = '{32'h101, 32'h102};
        logic [31:0] wds   [2] = '{32'h0000_00AB, 32'h1234_BEEF};
        logic [3:0]  bes   [2] = '{4'b0010, 4'b1100};
        logic [31:0] exps  [2] = '{32'h0000_AB00, 32'hBEEF_0000};
        int n0, r0, w0, u0;
        a_gnt_delay = 2;
        for (int i = 0; i < 2; i++) begin
            n0 = a_rsp_cnt; r0 = a_rd_cnt; w0 = a_wr_cnt; u0 = a_unstable;
            send_a(1'b1, f3s[i], addrs[i], wds[i], 5'd9);
            idle_wait(12);
            total++; if (a_wr_cnt - w0 != 1 || a_rd_cnt - r0 != 0) begin bad++; $display("[TB] FAIL st%0d_rw_counts got=%0d/%0d want=1/0", i, a_wr_cnt - w0, a_rd_cnt - r0); end
            total++; if (a_wr_be !== bes[i]) begin bad++; $display("[TB] FAIL st%0d_be got=%b want=%b", i, a_wr_be, bes[i]); end
            total++; if (a_wr_data !== exps[i]) begin bad++; $display("[TB] FAIL st%0d_wdata got=%h want=%h", i, a_wr_data, exps[i]); end
            total++; if (a_wr_addr !== 32'h100) begin bad++; $display("[TB] FAIL st%0d_addr got=%h want=00000100", i, a_wr_addr); end
            total++; if (a_rsp_cnt - n0 != 1 || a_l_we !== 1'b0 || a_l_data !== 32'h0) begin bad++; $display("[TB] FAIL st%0d_rsp cnt/we/data got=%0d/%b/%h want=1/0/0", i, a_rsp_cnt - n0, a_l_we, a_l_data); end
            total++; if (a_unstable != u0) begin bad++; $display("[TB] FAIL st%0d_stable got=%0d want=%0d", i, a_unstable, u0); end
        end
        a_gnt_delay = 0;
    endtask

    task automatic test_errors();
        logic        wes   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [2:0]  f3s   [4] = '{3'b010, 3'b011, 3'b100, 3'b001};
        logic [31:0] addrs [4] = '{32'h102, 32'h100, 32'h100, 32'h101};
        int n0, q0;
        for (int i = 0; i < 4; i++) begin
            n0 = a_rsp_cnt; q0 = a_req_cycles;
            send_a(wes[i], f3s[i], addrs[i], 32'hFFFF_FFFF, 5'd4);
            idle_wait(8);
            total++; if (a_req_cycles != q0) begin bad++; $display("[TB] FAIL err%0d_mem_req cycles got=%0d want=0", i, a_req_cycles - q0); end
            total++; if (a_rsp_cnt - n0 != 1 || a_l_err !== 1'b1) begin bad++; $display("[TB] FAIL err%0d_err cnt/err got=%0d/%b want=1/1", i, a_rsp_cnt - n0, a_l_err); end
            total++; if (a_l_we !== 1'b0 || a_l_data !== 32'h0) begin bad++; $display("[TB] FAIL err%0d_we_data got=%b/%h want=0/0", i, a_l_we, a_l_data); end
        end
    endtask

    task automatic test_xlen64();
        logic [2:0]  f3s  [2] = '{3'b110, 3'b010};
        logic [63:0] exps [2] = '{64'h0000_0000_F000_0001, 64'hFFFF_FFFF_F000_0001};
        int n0, r0, w0;
        b_gnt_delay = 0; b_rv_delay = 0; b_mem_word = 64'hF000_0001_0000_0000;
        for (int i = 0; i < 2; i++) begin
            n0 = b_rsp_cnt;
            send_b(1'b0, f3s[i], 32'h104, 64'h0, 5'd10);
            idle_wait(10);
            total++; if (b_rsp_cnt - n0 != 1 || b_l_data !== exps[i]) begin bad++; $display("[TB] FAIL ld64_%0d cnt/data got=%0d/%h want=1/%h", i, b_rsp_cnt - n0, b_l_data, exps[i]); end
            total++; if (b_l_we !== 1'b1 || b_rd_addr !== 32'h100) begin bad++; $display("[TB] FAIL ld64_%0d we/addr got=%b/%h want=1/00000100", i, b_l_we, b_rd_addr); end
        end
        r0 = b_rd_cnt; w0 = b_wr_cnt;
        send_b(1'b1, 3'b011, 32'h108, 64'h0123_4567_89AB_CDEF, 5'd0);
        idle_wait(10);
        total++; if (b_rd_cnt - r0 != 0 || b_wr_cnt - w0 != 1) begin bad++; $display("[TB] FAIL sd_counts rd/wr got=%0d/%0d want=0/1", b_rd_cnt - r0, b_wr_cnt - w0); end
        total++; if (b_wr_be !== 8'hFF || b_wr_addr !== 32'h108) begin bad++; $display("[TB] FAIL sd_be_addr got=%h/%h want=ff/00000108", b_wr_be, b_wr_addr); end
        total++; if (b_wr_data !== 64'h0123_4567_89AB_CDEF) begin bad++; $display("[TB] FAIL sd_wdata got=%h want=0123456789abcdef", b_wr_data); end
    endtask

    task automatic test_rmw();
        logic [2:0]  f3s  [2] = '{3'b000, 3'b010};
        logic [31:0] addrs[2] = '{32'h101, 32'h104};
        logic [63:0] wds  [2] = '{64'hAB, 64'hCAFE_F00D};
        logic [63:0] exps [2] = '{64'hDEAD_BEEF_1122_AB44, 64'hCAFE_F00D_1122_3344};
        int n0, r0, w0, u0;
        b_gnt_delay = 2; b_rv_delay = 1; b_mem_word = 64'hDEAD_BEEF_1122_3344;
        for (int i = 0; i < 2; i++) begin
            n0 = b_rsp_cnt; r0 = b_rd_cnt; w0 = b_wr_cnt; u0 = b_unstable;
            send_b(1'b1, f3s[i], addrs[i], wds[i], 5'd0);
            idle_wait(20);
            total++; if (b_rd_cnt - r0 != 1 || b_wr_cnt - w0 != 1) begin bad++; $display("[TB] FAIL rmw%0d_counts rd/wr got=%0d/%0d want=1/1", i, b_rd_cnt - r0, b_wr_cnt - w0); end
            total++; if (b_wr_data !== exps[i]) begin bad++; $display("[TB] FAIL rmw%0d_wdata got=%h want=%h", i, b_wr_data, exps[i]); end
            total++; if (b_wr_be !== 8'hFF || b_wr_addr !== 32'h100) begin bad++; $display("[TB] FAIL rmw%0d_be_addr got=%h/%h want=ff/00000100", i, b_wr_be, b_wr_addr); end
            total++; if (b_rsp_cnt - n0 != 1 || b_l_err !== 1'b0 || b_l_we !== 1'b0) begin bad++; $display("[TB] FAIL rmw%0d_rsp cnt/err/we got=%0d/%b/%b want=1/0/0", i, b_rsp_cnt - n0, b_l_err, b_l_we); end
            total++; if (b_unstable != u0) begin bad++; $display("[TB] FAIL rmw%0d_stable got=%0d want=%0d", i, b_unstable, u0); end
        end
        b_gnt_delay = 0; b_rv_delay = 0;
    endtask

    // Grant held off three cycles, reset while waiting for read data; the
    // stale return afterwards must not produce a response.
    task automatic test_reset_midop();
        int n0, r0, w0, q0, u0;
        a_gnt_delay = 3; a_rv_delay = 5; a_mem_word = 32'h5555_AAAA;
        n0 = a_rsp_cnt; r0 = a_rd_cnt; w0 = a_wr_cnt; q0 = a_req_cycles; u0 = a_unstable;
        send_a(1'b0, 3'b010, 32'h100, 32'h0, 5'd12);
        for (int i = 0; i < 20 && a_rd_cnt == r0; i++) @(posedge clk);
        #1;
        total++; if (a_rd_cnt - r0 != 1) begin bad++; $display("[TB] FAIL midop_grant got=%0d want=1", a_rd_cnt - r0); end
        total++; if (a_req_cycles - q0 != 4 || a_unstable != u0) begin bad++; $display("[TB] FAIL midop_hold cycles/unstable got=%0d/%0d want=4/%0d", a_req_cycles - q0, a_unstable, u0); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (a_req_ready !== 1'b1 || a_mem_req !== 1'b0) begin bad++; $display("[TB] FAIL midop_idle ready/req got=%b/%b want=1/0", a_req_ready, a_mem_req); end
        @(negedge clk);
        rst = 1'b0;
        idle_wait(15);
        total++; if (a_rsp_cnt != n0 || a_wr_cnt != w0) begin bad++; $display("[TB] FAIL midop_no_rsp rsp/wr got=%0d/%0d want=0/0", a_rsp_cnt - n0, a_wr_cnt - w0); end
        total++; if (a_req_ready !== 1'b1) begin bad++; $display("[TB] FAIL midop_ready got=%b want=1", a_req_ready); end
        a_gnt_delay = 0; a_rv_delay = 0; a_mem_word = 32'h0000_00FF;
        n0 = a_rsp_cnt;
        send_a(1'b0, 3'b000, 32'h100, 32'h0, 5'd13);
        idle_wait(10);
        total++; if (a_rsp_cnt - n0 != 1 || a_l_data !== 32'hFFFF_FFFF) begin bad++; $display("[TB] FAIL midop_recover cnt/data got=%0d/%h want=1/ffffffff", a_rsp_cnt - n0, a_l_data); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_load_ext();
        test_store_be();
        test_errors();
        test_xlen64();
        test_rmw();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
